prbs_checker: RTL



---
 rtl/prbs_pkg.sv | 26 ++
 rtl/prbs_checker_lfsr.sv | 50 +++++
 rtl/prbs_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker FSM encodings, ITU polynomial constants (top term implied) and a popcount helper.
package prbs_pkg;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } prbs_state_t;

  localparam logic [6:0]  PRBS7_POLY  = 7'h41;
  localparam logic [8:0]  PRBS9_POLY  = 9'h021;
  localparam logic [14:0] PRBS15_POLY = 15'h4001;
  localparam logic [22:0] PRBS23_POLY = 23'h040001;
  localparam logic [30:0] PRBS31_POLY = 31'h10000001;

  localparam int POPCOUNT_W = 256;

  function automatic int unsigned popcount(input logic [POPCOUNT_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCOUNT_W; i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs_checker_lfsr.sv
// Parallel Fibonacci LFSR, DATA_WIDTH bits per evaluation; purely combinational.
// Feed-forward mode shifts received bits into the state so data_out is the per-bit sync error.
module prbs_checker_lfsr #(
  parameter int                    LFSR_WIDTH        = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 31'h10000001,
  parameter                        LFSR_CONFIG       = "FIBONACCI",
  parameter int                    LFSR_FEED_FORWARD = 1,
  parameter int                    REVERSE           = 0,
  parameter int                    DATA_WIDTH        = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);
  import prbs_pkg::*;

  generate
    if (LFSR_CONFIG != "FIBONACCI") begin : g_bad_config
      $error("prbs_checker_lfsr: only FIBONACCI configuration is implemented");
    end
  endgenerate

  // Poly bit j taps state bit j-1; bit 0 is the constant term and carries no tap.
  always_comb begin : p_shift
    logic [LFSR_WIDTH-1:0] v_state;
    logic                  v_fb;
    logic                  v_bit;
    int                    v_idx;
    v_state  = state_in;
    v_fb     = 1'b0;
    v_bit    = 1'b0;
    v_idx    = 0;
    data_out = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      v_idx = (REVERSE != 0) ? k : (DATA_WIDTH - 1 - k);
      v_fb  = v_state[LFSR_WIDTH-1];
      for (int j = 1; j < LFSR_WIDTH; j++) begin
        if (LFSR_POLY[j]) begin
          v_fb = v_fb ^ v_state[j-1];
        end
      end
      v_bit           = data_in[v_idx];
      data_out[v_idx] = v_fb ^ v_bit;
      v_state = {v_state[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD != 0) ? v_bit : (v_fb ^ v_bit)};
    end
    state_out = v_state;
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: feed-forward sync, lock FSM, saturating error counters; PRBS_CHECKER_INVERT_EN checks inverted PRBS.
// Status/counters update 1 cycle after a valid word; no backpressure, data_in_valid low holds all state.
module prbs_checker #(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter int                    REVERSE      = 0,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LOCK_COUNT   = 16,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  input  logic                   clear_count,
  output logic                   locked,
  output logic                   error_word,
  output logic [COUNT_WIDTH-1:0] error_bit_count,
  output logic [COUNT_WIDTH-1:0] error_word_count
);
  import prbs_pkg::*;

  localparam int ECW      = $clog2(DATA_WIDTH + 1);
  localparam int LCW      = $clog2(LOCK_COUNT + 1);
  localparam int UCW      = $clog2(UNLOCK_COUNT + 1);
  localparam int SUM_W    = ((COUNT_WIDTH > ECW) ? COUNT_WIDTH : ECW) + 1;
  localparam int MIN_LOCK = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  generate
    if (LOCK_COUNT <= MIN_LOCK) begin : g_bad_lock
      $error("prbs_checker: LOCK_COUNT must exceed ceil(LFSR_WIDTH/DATA_WIDTH)");
    end
    if (UNLOCK_COUNT < 1) begin : g_bad_unlock
      $error("prbs_checker: UNLOCK_COUNT must be at least 1");
    end
    if (DATA_WIDTH > POPCOUNT_W) begin : g_bad_width
      $error("prbs_checker: DATA_WIDTH exceeds popcount width");
    end
  endgenerate

  logic [DATA_WIDTH-1:0]  w_data;
  logic [DATA_WIDTH-1:0]  w_err_vec;
  logic [LFSR_WIDTH-1:0]  w_next_hist;
  logic [ECW-1:0]         w_err_cnt;
  logic                   w_word_err;
  logic [SUM_W-1:0]       w_bit_sum;
  logic [COUNT_WIDTH-1:0] w_bit_sat;
  logic [COUNT_WIDTH-1:0] w_word_sat;

  prbs_state_t            r_state;
  logic [LFSR_WIDTH-1:0]  r_hist;
  logic [LCW-1:0]         r_lock_ctr;
  logic [UCW-1:0]         r_unlock_ctr;
  logic                   r_locked;
  logic                   r_error_word;
  logic [COUNT_WIDTH-1:0] r_bit_cnt;
  logic [COUNT_WIDTH-1:0] r_word_cnt;

`ifdef PRBS_CHECKER_INVERT_EN
  assign w_data = ~data_in;
`else
  assign w_data = data_in;
`endif

  prbs_checker_lfsr #(
    .LFSR_WIDTH        (LFSR_WIDTH),
    .LFSR_POLY         (LFSR_POLY),
    .LFSR_CONFIG       ("FIBONACCI"),
    .LFSR_FEED_FORWARD (1),
    .REVERSE           (REVERSE),
    .DATA_WIDTH        (DATA_WIDTH)
  ) u_lfsr (
    .data_in   (w_data),
    .state_in  (r_hist),
    .data_out  (w_err_vec),
    .state_out (w_next_hist)
  );

  assign w_err_cnt  = ECW'(popcount(POPCOUNT_W'(w_err_vec)));
  assign w_word_err = |w_err_vec;

  // Widened sum catches a partial add that would overflow the counter.
  assign w_bit_sum  = SUM_W'(r_bit_cnt) + SUM_W'(w_err_cnt);
  assign w_bit_sat  = (w_bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_bit_sum[COUNT_WIDTH-1:0];
  assign w_word_sat = (&r_word_cnt) ? r_word_cnt : (r_word_cnt + 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_UNLOCKED;
      r_hist       <= '0;
      r_lock_ctr   <= '0;
      r_unlock_ctr <= '0;
      r_locked     <= 1'b0;
      r_error_word <= 1'b0;
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
    end else begin
      r_error_word <= 1'b0;
      if (clear_count) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
      end
      if (data_in_valid) begin
        r_hist <= w_next_hist;
        case (r_state)
          ST_UNLOCKED: begin
            if (w_word_err) begin
              r_lock_ctr <= '0;
            end else if (r_lock_ctr == LCW'(LOCK_COUNT - 1)) begin
              r_lock_ctr   <= LCW'(LOCK_COUNT);
              r_unlock_ctr <= '0;
              r_state      <= ST_LOCKED;
              r_locked     <= 1'b1;
            end else begin
              r_lock_ctr <= r_lock_ctr + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (w_word_err) begin
              r_error_word <= 1'b1;
              if (!clear_count) begin
                r_bit_cnt  <= w_bit_sat;
                r_word_cnt <= w_word_sat;
              end
              // The word that drops lock is still counted above.
              if (r_unlock_ctr == UCW'(UNLOCK_COUNT - 1)) begin
                r_unlock_ctr <= UCW'(UNLOCK_COUNT);
                r_lock_ctr   <= '0;
                r_state      <= ST_UNLOCKED;
                r_locked     <= 1'b0;
              end else begin
                r_unlock_ctr <= r_unlock_ctr + 1'b1;
              end
            end else begin
              r_unlock_ctr <= '0;
            end
          end
          default: begin
            r_state  <= ST_UNLOCKED;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked           = r_locked;
  assign error_word       = r_error_word;
  assign error_bit_count  = r_bit_cnt;
  assign error_word_count = r_word_cnt;

endmodule
